fpu_addsub_pipe: RTL and testbench
==================================

// Module: fpu_addsub_pipe
// PURPOSE
// Parametrised, 3-stage pipelined floating-point add/subtract core with a valid/ready handshake.
// It generalises the single-precision add path to any IEEE-style EXP_W/MAN_W format, adds subtract mode and a tag.
// It handles IEEE special cases, including NaN from inf-inf and signed zero.
// It emits an unrounded, normalised result (hidden bit plus 3 guard/round/sticky bits) to the downstream fpu rounder.
// PARAMETERS
// EXP_W   8   exponent field width; legal range 4..11
// MAN_W   23  stored mantissa width, without the hidden bit; legal range 3..52
// TAG_W   4   opaque tag width; the tag is carried alongside the operands unchanged
// PORTS
// clk           in   1                 clock
// rst_n         in   1                 asynchronous active-low reset
// in_valid      in   1                 operand beat valid
// in_ready      out  1                 core can accept a beat
// in_a, in_b    in   1+EXP_W+MAN_W     packed {sign, exponent, mantissa} operands
// in_sub        in   1                 1 = compute a-b (invert b sign at capture)
// in_mode       in   3                 fpu_round_mode_t; carried through, and consulted for zero sign
// in_tag        in   TAG_W             passthrough tag
// out_valid     out  1                 result valid
// out_ready     in   1                 downstream accepts the result
// out_sign      out  1                 result sign
// out_exponent  out  EXP_W             biased result exponent
// out_mantissa  out  MAN_W+1           normalised significand including the hidden bit
// out_guard     out  3                 guard, round, sticky bits
// out_nan, out_inf, out_zero  out  1   special-result flags
// out_mode      out  3                 round mode of this beat
// out_tag       out  TAG_W             tag of this beat
// BEHAVIOUR
// Reset: all stage valids and every output register cleared to 0.
//   After reset, out_valid=0 and in_ready=1.
// Reset is asynchronous: asserting it mid-operation discards all in-flight beats; none reappear.
// Handshake: adv = !out_valid | out_ready. All three stages advance together on adv.
//   in_ready = adv (combinational from out_ready).
//   A beat is captured when in_valid & in_ready.
//   Latency is exactly 3 cycles with no stalls; throughput is 1 beat/cycle.
//   While out_valid & !out_ready, every output and internal stage holds unchanged.
// S1 align:
//   Operand classification: exp==0 is subnormal; the effective exponent is exp + !norm.
//   The larger-exponent operand becomes A. Equal exponents keep in_a as A.
//   shift = diffexp clamped to MAN_W+4.
//   B is shifted right by shift; the shifted-out bits OR into the sticky LSB.
//   Working significand width is MAN_W+4: hidden, mantissa, 3 guard bits.
// S2 add:
//   Same effective sign: sum = A+B with a carry bit.
//   Opposite signs: subtract the smaller magnitude from the larger.
//   The result sign takes the larger magnitude's sign. For equal magnitudes see the zero rule.
// S3 normalise:
//   Carry set: shift right by 1 with sticky OR and exponent +1.
//     If the exponent reaches all-ones, set out_inf=1 and clear mantissa/guard.
//   Otherwise shift left by lz, where lz = min(leading zeros, exp-1).
//     If the MSB is still 0 after the shift, out_exponent=0 (subnormal result).
//   A zero sum gives out_exponent=0, out_mantissa=0, out_zero=1.
// Specials, resolved in S1 and carried as flags:
//   Either operand NaN, or inf + (-inf) after sub inversion: out_nan=1, sign 0.
//   Otherwise either operand inf: out_inf=1 with the sign of that inf.
//   Zero sign rule: exact cancellation of opposite signs gives sign = (in_mode==RDN).
//   Two zeros of the same sign keep that sign.
// No exceptions or flags besides these; the rounder owns inexact and overflow reporting.
// STRUCTURE
// Add to package fpu_utils:
//   typedef fpu_addsub_s1_t / fpu_addsub_s2_t (parametrised widths via localparams WORK_W=MAN_W+4).
//   function get_sticky_bit_n (width-generic sticky).
//   function get_leading_zeros_n (width-generic leading-zero count).
//   localparam FPU_RDN = 3'b010.
// One sub-module: fpu_addsub_lzc (WIDTH param, priority-tree leading-zero count) instantiated in S3.
// TESTING (EXP_W=8, MAN_W=23 unless noted)
// 1. 3F800000+3F800000, RNE -> after 3 cycles:
//    exp=0x80, mant=0x800000, guard=0, sign=0, no flags.
// 2. 3F800000 sub 3F800000:
//    RNE -> out_zero=1, sign=0.
//    RDN (in_mode=2) -> out_zero=1, sign=1.
// 3. 7F800000 sub 7F800000 -> out_nan=1.
//    7F800000+3F800000 -> out_inf=1, sign=0.
//    7FC00000+any -> out_nan=1.
// 4. 7F7FFFFF+7F7FFFFF -> out_inf=1.
//    00000001+00000001 -> exp=0, mant=0x000002.
//    3F800000+33800000 (2^-24) -> guard=3'b100.
// 5. Stream 6 beats, tags 0..5.
//    Hold out_ready=0 for cycles 4..8 -> in_ready=0 while stalled, outputs stable.
//    Tags emerge 0..5 in order with no loss or duplication.
// 6. Assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately; no stale beat after release.
//    EXP_W=5, MAN_W=10: 3C00+3C00 -> exp=0x10, mant=0x400.

Source files
------------

// File: rtl/fpu_addsub_pipe_pkg.sv
// Purpose: shared fpu_utils helpers: round-mode encoding and width-generic sticky / leading-zero functions.
// Latency: n/a (package, purely combinational helpers).
// Backpressure: n/a.
package fpu_utils;

  // Widest vector the helpers accept (MAN_W+4 <= 56 fits comfortably).
  localparam int FPU_MAX_W = 64;

  typedef logic [2:0] fpu_round_mode_t;

  localparam fpu_round_mode_t FPU_RNE = 3'b000;
  localparam fpu_round_mode_t FPU_RDN = 3'b010;

  // OR of the n least-significant bits of v (bits shifted out by a right shift of n).
  function automatic logic get_sticky_bit_n(input logic [FPU_MAX_W-1:0] v, input int n);
    logic s;
    s = 1'b0;
    for (int i = 0; i < FPU_MAX_W; i++) begin
      if (i < n) s = s | v[i];
    end
    return s;
  endfunction

  // Leading zeros of the low w bits of v; returns w for an all-zero field.
  // Scanning upwards lets the highest set bit win the priority.
  function automatic int get_leading_zeros_n(input logic [FPU_MAX_W-1:0] v, input int w);
    int lz;
    lz = w;
    for (int i = 0; i < FPU_MAX_W; i++) begin
      if ((i < w) && v[i]) lz = w - 1 - i;
    end
    return lz;
  endfunction

endpackage

// File: rtl/fpu_addsub_lzc.sv
// Purpose: WIDTH-generic priority leading-zero counter used by the normalise stage.
// Latency: combinational.
// Backpressure: none (pure function of data_i).
// Ports: data_i - value to scan (MSB first); count_o - number of leading zeros (WIDTH when zero).
module fpu_addsub_lzc
  import fpu_utils::*;
#(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = CNT_W'(get_leading_zeros_n(FPU_MAX_W'(data_i), WIDTH));
  end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Purpose: 3-stage pipelined IEEE-style add/subtract (align, add, normalise); emits an unrounded result plus G/R/S.
// Latency: 3 cycles, 1 beat/cycle; all stages advance together when the output is empty or being taken.
// Backpressure: in_ready = !out_valid | out_ready; while out_valid & !out_ready everything holds.
// Ports: in_* operand beat (a, b, sub, round mode, tag) with valid/ready; out_* result fields,
//        special flags (nan/inf/zero), and the beat's mode and tag, with valid/ready.
module fpu_addsub_pipe
  import fpu_utils::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_sub,
  input  logic [2:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [EXP_W-1:0]         out_exponent,
  output logic [MAN_W:0]           out_mantissa,
  output logic [2:0]               out_guard,
  output logic                     out_nan,
  output logic                     out_inf,
  output logic                     out_zero,
  output logic [2:0]               out_mode,
  output logic [TAG_W-1:0]         out_tag
);

  // Working significand: hidden bit, stored mantissa, guard/round/sticky.
  localparam int WORK_W = MAN_W + 4;
  localparam int CNT_W  = $clog2(WORK_W + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef struct packed {
    logic              vld;
    logic              sign_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp;
    logic [WORK_W-1:0] sig_a;
    logic [WORK_W-1:0] sig_b;
    logic              nan;
    logic              inf;
    logic              inf_sign;
    fpu_round_mode_t   mode;
    logic [TAG_W-1:0]  tag;
  } fpu_addsub_s1_t;

  typedef struct packed {
    logic              vld;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [WORK_W:0]   sum;
    logic              nan;
    logic              inf;
    logic              inf_sign;
    fpu_round_mode_t   mode;
    logic [TAG_W-1:0]  tag;
  } fpu_addsub_s2_t;

  typedef struct packed {
    logic              vld;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MAN_W:0]    mant;
    logic [2:0]        guard;
    logic              nan;
    logic              inf;
    logic              zero;
    fpu_round_mode_t   mode;
    logic [TAG_W-1:0]  tag;
  } fpu_addsub_res_t;

  fpu_addsub_s1_t  s1_q, s1_d;
  fpu_addsub_s2_t  s2_q, s2_d;
  fpu_addsub_res_t res_q, res_d;

  logic adv;
  assign adv      = !res_q.vld || out_ready;
  assign in_ready = adv;

  // ---------------- S1: classify, order, align ----------------
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff, big_e, small_e, diff_e;
  logic [MAN_W-1:0]  ma, mb;
  logic [WORK_W-1:0] sig_ia, sig_ib, sig_big, sig_small;
  logic              a_nan, b_nan, a_inf, b_inf, swap, sticky;
  int                shift_n;

  assign sa = in_a[EXP_W+MAN_W];
  assign ea = in_a[EXP_W+MAN_W-1:MAN_W];
  assign ma = in_a[MAN_W-1:0];
  // Subtract is folded in here so later stages only ever add signed magnitudes.
  assign sb = in_b[EXP_W+MAN_W] ^ in_sub;
  assign eb = in_b[EXP_W+MAN_W-1:MAN_W];
  assign mb = in_b[MAN_W-1:0];

  // Subnormals share the scale of exponent 1 but carry no hidden bit.
  assign ea_eff = (ea == '0) ? EXP_W'(1) : ea;
  assign eb_eff = (eb == '0) ? EXP_W'(1) : eb;
  assign sig_ia = {ea != '0, ma, 3'b000};
  assign sig_ib = {eb != '0, mb, 3'b000};

  assign a_nan = (ea == EXP_ONES) && (ma != '0);
  assign b_nan = (eb == EXP_ONES) && (mb != '0);
  assign a_inf = (ea == EXP_ONES) && (ma == '0);
  assign b_inf = (eb == EXP_ONES) && (mb == '0);

  // Ties keep in_a as the larger operand.
  assign swap      = eb_eff > ea_eff;
  assign big_e     = swap ? eb_eff : ea_eff;
  assign small_e   = swap ? ea_eff : eb_eff;
  assign sig_big   = swap ? sig_ib : sig_ia;
  assign sig_small = swap ? sig_ia : sig_ib;
  assign diff_e    = big_e - small_e;

  always_comb begin
    // Beyond WORK_W every bit is already sticky, so clamp the shifter.
    shift_n = (int'(diff_e) > WORK_W) ? WORK_W : int'(diff_e);
    sticky  = get_sticky_bit_n(FPU_MAX_W'(sig_small), shift_n);

    s1_d          = '0;
    s1_d.vld      = in_valid;
    s1_d.sign_a   = swap ? sb : sa;
    s1_d.sign_b   = swap ? sa : sb;
    s1_d.exp      = big_e;
    s1_d.sig_a    = sig_big;
    s1_d.sig_b    = (sig_small >> shift_n) | WORK_W'(sticky);
    s1_d.nan      = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
    s1_d.inf      = !s1_d.nan && (a_inf || b_inf);
    s1_d.inf_sign = a_inf ? sa : sb;
    s1_d.mode     = in_mode;
    s1_d.tag      = in_tag;
  end

  // ---------------- S2: magnitude add / subtract ----------------
  always_comb begin
    s2_d          = '0;
    s2_d.vld      = s1_q.vld;
    s2_d.exp      = s1_q.exp;
    s2_d.nan      = s1_q.nan;
    s2_d.inf      = s1_q.inf;
    s2_d.inf_sign = s1_q.inf_sign;
    s2_d.mode     = s1_q.mode;
    s2_d.tag      = s1_q.tag;
    if (s1_q.sign_a == s1_q.sign_b) begin
      // Also covers two same-signed zeros, which keep their sign.
      s2_d.sum  = {1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b};
      s2_d.sign = s1_q.sign_a;
    end else if (s1_q.sig_a > s1_q.sig_b) begin
      s2_d.sum  = {1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b};
      s2_d.sign = s1_q.sign_a;
    end else if (s1_q.sig_b > s1_q.sig_a) begin
      s2_d.sum  = {1'b0, s1_q.sig_b} - {1'b0, s1_q.sig_a};
      s2_d.sign = s1_q.sign_b;
    end else begin
      // Exact cancellation: -0 only when rounding toward negative infinity.
      s2_d.sum  = '0;
      s2_d.sign = (s1_q.mode == FPU_RDN);
    end
  end

  // ---------------- S3: normalise ----------------
  logic [CNT_W-1:0]  lz;
  logic [WORK_W-1:0] norm;
  logic [EXP_W-1:0]  exp_inc;
  int                lim_n;

  fpu_addsub_lzc #(.WIDTH(WORK_W), .CNT_W(CNT_W)) u_lzc (
    .data_i  (s2_q.sum[WORK_W-1:0]),
    .count_o (lz)
  );

  assign exp_inc = s2_q.exp + EXP_W'(1);

  always_comb begin
    res_d      = '0;
    res_d.vld  = s2_q.vld;
    res_d.sign = s2_q.sign;
    res_d.mode = s2_q.mode;
    res_d.tag  = s2_q.tag;
    norm       = '0;
    lim_n      = 0;
    if (s2_q.nan) begin
      // Canonical NaN is reported through the flag; payload is not propagated.
      res_d.nan  = 1'b1;
      res_d.sign = 1'b0;
      res_d.exp  = EXP_ONES;
    end else if (s2_q.inf) begin
      res_d.inf  = 1'b1;
      res_d.sign = s2_q.inf_sign;
      res_d.exp  = EXP_ONES;
    end else if (s2_q.sum[WORK_W]) begin
      if (exp_inc == EXP_ONES) begin
        res_d.inf = 1'b1;
        res_d.exp = EXP_ONES;
      end else begin
        norm        = s2_q.sum[WORK_W:1] | WORK_W'(s2_q.sum[0]);
        res_d.exp   = exp_inc;
        res_d.mant  = norm[WORK_W-1:3];
        res_d.guard = norm[2:0];
      end
    end else if (s2_q.sum == '0) begin
      res_d.zero = 1'b1;
    end else begin
      // Never shift below exponent 1; what is still unnormalised is a subnormal.
      lim_n = int'(lz);
      if (lim_n > int'(s2_q.exp) - 1) lim_n = int'(s2_q.exp) - 1;
      norm        = s2_q.sum[WORK_W-1:0] << lim_n;
      res_d.exp   = norm[WORK_W-1] ? (s2_q.exp - EXP_W'(lim_n)) : '0;
      res_d.mant  = norm[WORK_W-1:3];
      res_d.guard = norm[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      res_q <= '0;
    end else if (adv) begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      res_q <= res_d;
    end
  end

  assign out_valid    = res_q.vld;
  assign out_sign     = res_q.sign;
  assign out_exponent = res_q.exp;
  assign out_mantissa = res_q.mant;
  assign out_guard    = res_q.guard;
  assign out_nan      = res_q.nan;
  assign out_inf      = res_q.inf;
  assign out_zero     = res_q.zero;
  assign out_mode     = res_q.mode;
  assign out_tag      = res_q.tag;

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
module tb_fpu_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // single-precision instance
  logic        in_valid = 1'b0, in_ready, in_sub = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_mode = '0, out_mode;
  logic [3:0]  in_tag = '0, out_tag;
  logic        out_valid, out_ready = 1'b1, out_sign, out_nan, out_inf, out_zero;
  logic [7:0]  out_exponent;
  logic [23:0] out_mantissa;
  logic [2:0]  out_guard;

  // half-precision instance
  logic        h_in_valid = 1'b0, h_in_ready, h_in_sub = 1'b0;
  logic [15:0] h_in_a = '0, h_in_b = '0;
  logic [2:0]  h_in_mode = '0, h_out_mode;
  logic [3:0]  h_in_tag = '0, h_out_tag;
  logic        h_out_valid, h_out_ready = 1'b1, h_out_sign, h_out_nan, h_out_inf, h_out_zero;
  logic [4:0]  h_out_exponent;
  logic [10:0] h_out_mantissa;
  logic [2:0]  h_out_guard;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exponent(out_exponent), .out_mantissa(out_mantissa), .out_guard(out_guard),
    .out_nan(out_nan), .out_inf(out_inf), .out_zero(out_zero),
    .out_mode(out_mode), .out_tag(out_tag)
  );

  fpu_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_sub(h_in_sub), .in_mode(h_in_mode), .in_tag(h_in_tag),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_sign(h_out_sign),
    .out_exponent(h_out_exponent), .out_mantissa(h_out_mantissa), .out_guard(h_out_guard),
    .out_nan(h_out_nan), .out_inf(h_out_inf), .out_zero(h_out_zero),
    .out_mode(h_out_mode), .out_tag(h_out_tag)
  );

  // Drive one beat and wait (bounded) for its result; lat = 99 when nothing appears.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [2:0] mode, input logic [3:0] tag, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_mode = mode; in_tag = tag; in_valid = 1'b1;
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_checks++; if ({out_nan, out_inf, out_zero, out_exponent} !== 11'd0) begin n_fail++; $display("FAIL reset_outputs got=%b%b%b %h want=0", out_nan, out_inf, out_zero, out_exponent); end
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    send_one(32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 4'h5, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency got=%0d want=3", lat); end
    n_checks++; if (out_exponent !== 8'h80) begin n_fail++; $display("FAIL add_exp got=%h want=80", out_exponent); end
    n_checks++; if (out_mantissa !== 24'h800000) begin n_fail++; $display("FAIL add_mant got=%h want=800000", out_mantissa); end
    n_checks++; if (out_guard !== 3'b000) begin n_fail++; $display("FAIL add_guard got=%b want=000", out_guard); end
    n_checks++; if (out_sign !== 1'b0) begin n_fail++; $display("FAIL add_sign got=%b want=0", out_sign); end
    n_checks++; if ({out_nan, out_inf, out_zero} !== 3'b000) begin n_fail++; $display("FAIL add_flags got=%b want=000", {out_nan, out_inf, out_zero}); end
    n_checks++; if (out_tag !== 4'h5) begin n_fail++; $display("FAIL add_tag got=%h want=5", out_tag); end
    // 1.5 - 1.0 = 0.5 : left normalisation by one
    send_one(32'h3FC00000, 32'h3F800000, 1'b1, 3'd3, 4'h6, lat);
    n_checks++; if ({out_sign, out_exponent, out_mantissa} !== {1'b0, 8'h7E, 24'h800000}) begin n_fail++; $display("FAIL sub_half got=%b %h %h want=0 7e 800000", out_sign, out_exponent, out_mantissa); end
    n_checks++; if (out_mode !== 3'd3) begin n_fail++; $display("FAIL sub_mode got=%0d want=3", out_mode); end
    // 1.0 - 1.5 = -0.5 : B has the larger magnitude
    send_one(32'h3F800000, 32'h3FC00000, 1'b1, 3'd0, 4'h7, lat);
    n_checks++; if ({out_sign, out_exponent, out_mantissa} !== {1'b1, 8'h7E, 24'h800000}) begin n_fail++; $display("FAIL sub_neg got=%b %h %h want=1 7e 800000", out_sign, out_exponent, out_mantissa); end
  endtask

  task automatic test_zero_sign();
    int lat;
    send_one(32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 4'h1, lat);
    n_checks++; if ({out_zero, out_sign, out_exponent} !== {1'b1, 1'b0, 8'h00}) begin n_fail++; $display("FAIL zero_rne got=z%b s%b e%h want=z1 s0 e00", out_zero, out_sign, out_exponent); end
    send_one(32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 4'h2, lat);
    n_checks++; if ({out_zero, out_sign} !== 2'b11) begin n_fail++; $display("FAIL zero_rdn got=z%b s%b want=z1 s1", out_zero, out_sign); end
    // -0 + -0 keeps its sign even in RNE
    send_one(32'h80000000, 32'h80000000, 1'b0, 3'd0, 4'h3, lat);
    n_checks++; if ({out_zero, out_sign} !== 2'b11) begin n_fail++; $display("FAIL zero_negneg got=z%b s%b want=z1 s1", out_zero, out_sign); end
  endtask

  task automatic test_specials();
    int lat;
    send_one(32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 4'h0, lat);
    n_checks++; if ({out_nan, out_inf, out_sign} !== 3'b100) begin n_fail++; $display("FAIL inf_minus_inf got=n%b i%b s%b want=n1 i0 s0", out_nan, out_inf, out_sign); end
    send_one(32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 4'h0, lat);
    n_checks++; if ({out_nan, out_inf, out_sign} !== 3'b010) begin n_fail++; $display("FAIL inf_plus_one got=n%b i%b s%b want=n0 i1 s0", out_nan, out_inf, out_sign); end
    send_one(32'h3F800000, 32'hFF800000, 1'b0, 3'd0, 4'h0, lat);
    n_checks++; if ({out_nan, out_inf, out_sign} !== 3'b011) begin n_fail++; $display("FAIL one_plus_neginf got=n%b i%b s%b want=n0 i1 s1", out_nan, out_inf, out_sign); end
    send_one(32'h7FC00000, 32'h3F800000, 1'b0, 3'd0, 4'h0, lat);
    n_checks++; if ({out_nan, out_inf} !== 2'b10) begin n_fail++; $display("FAIL qnan_plus got=n%b i%b want=n1 i0", out_nan, out_inf); end
  endtask

  task automatic test_boundaries();
    int lat;
    send_one(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 4'h0, lat);
    n_checks++; if ({out_inf, out_nan, out_mantissa, out_guard} !== {2'b10, 24'h0, 3'b000}) begin n_fail++; $display("FAIL overflow got=i%b n%b m%h g%b want=i1 n0 m0 g0", out_inf, out_nan, out_mantissa, out_guard); end
    send_one(32'h00000001, 32'h00000001, 1'b0, 3'd0, 4'h0, lat);
    n_checks++; if ({out_exponent, out_mantissa, out_zero} !== {8'h00, 24'h000002, 1'b0}) begin n_fail++; $display("FAIL subnormal got=e%h m%h z%b want=e00 m000002 z0", out_exponent, out_mantissa, out_zero); end
    send_one(32'h3F800000, 32'h33800000, 1'b0, 3'd0, 4'h0, lat);
    n_checks++; if ({out_exponent, out_mantissa, out_guard} !== {8'h7F, 24'h800000, 3'b100}) begin n_fail++; $display("FAIL guard_bit got=e%h m%h g%b want=e7f m800000 g100", out_exponent, out_mantissa, out_guard); end
    // 1.0 + 2^-40: everything lands in sticky
    send_one(32'h3F800000, 32'h2B800000, 1'b0, 3'd0, 4'h0, lat);
    n_checks++; if ({out_exponent, out_mantissa, out_guard} !== {8'h7F, 24'h800000, 3'b001}) begin n_fail++; $display("FAIL sticky_bit got=e%h m%h g%b want=e7f m800000 g001", out_exponent, out_mantissa, out_guard); end
  endtask

  task automatic test_back_to_back();
    int  sent = 0, rcv = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_tag = '0;
    logic [23:0] prev_mant = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !((c >= 4) && (c <= 8));
      in_valid  = (sent < 6);
      in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0; in_mode = 3'd0;
      in_tag = 4'(sent);
      #1;
      if (out_valid && !out_ready) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready); end
        if (prev_stall) begin
          n_checks++; if ({out_tag, out_mantissa} !== {prev_tag, prev_mant}) begin n_fail++; $display("FAIL stall_hold c=%0d got=%h %h want=%h %h", c, out_tag, out_mantissa, prev_tag, prev_mant); end
        end
        prev_stall = 1'b1; prev_tag = out_tag; prev_mant = out_mantissa;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_checks++; if ({out_tag, out_exponent} !== {4'(rcv), 8'h80}) begin n_fail++; $display("FAIL stream_order got=t%h e%h want=t%h e80", out_tag, out_exponent, 4'(rcv)); end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (rcv !== 6) begin n_fail++; $display("FAIL stream_count got=%0d want=6", rcv); end
  endtask

  task automatic test_reset_in_flight();
    int stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0; in_tag = 4'(8 + i); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flight_present got=%b want=1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_reset_valid got=%b want=0", out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL flight_stale got=%0d want=0", stale); end
  endtask

  task automatic test_half();
    int lat = 99;
    @(negedge clk);
    h_in_a = 16'h3C00; h_in_b = 16'h3C00; h_in_tag = 4'h9; h_in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      h_in_valid = 1'b0;
      if (h_out_valid) begin
        lat = i;
        break;
      end
    end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL half_latency got=%0d want=3", lat); end
    n_checks++; if ({h_out_exponent, h_out_mantissa, h_out_guard} !== {5'h10, 11'h400, 3'b000}) begin n_fail++; $display("FAIL half_add got=e%h m%h g%b want=e10 m400 g000", h_out_exponent, h_out_mantissa, h_out_guard); end
    n_checks++; if (h_out_tag !== 4'h9) begin n_fail++; $display("FAIL half_tag got=%h want=9", h_out_tag); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_zero_sign();
    test_specials();
    test_boundaries();
    test_back_to_back();
    test_reset_in_flight();
    test_half();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
